// File: rtl/sprite_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_loader_pkg: sprite record types, loader states, address helper |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sprite_loader_pkg;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [1:0] w;
    logic [1:0] h;
    logic [9:0] tile;
    logic [3:0] palette;
    logic       x_mirror;
    logic       y_mirror;
    logic       fg_prio;
    logic       bg_prio;
  } sprite_conf_t;

  // pat[0] sits in the low nibble so a pattern word maps straight onto 8 slots
  typedef struct packed {
    sprite_conf_t     conf;
    logic [31:0][3:0] pat;
  } sprite_reg_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CLEAR      = 3'd1,
    S_SCAN_ADDR  = 3'd2,
    S_SCAN_CHECK = 3'd3,
    S_FETCH_ADDR = 3'd4,
    S_FETCH_DATA = 3'd5,
    S_PUSH       = 3'd6,
    S_DONE       = 3'd7
  } loader_state_t;

  // Tile rows are four tiles apart; the 10-bit sum wraps naturally
  function automatic logic [12:0] pat_word(input logic [9:0] tile, input logic [1:0] ty,
                                           input logic [1:0] k, input logic [2:0] py);
    logic [9:0] tile_id;
    tile_id = tile + {6'd0, ty, 2'b00} + {8'd0, k};
    return {tile_id, py};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_loader_if: control, OAM/pattern memory and chain-head signals  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sprite_loader_if
  import sprite_loader_pkg::*;
#(
  parameter int NUM_OAM = 64
) ();

  logic                       start;
  logic [7:0]                 next_row;
  logic [$clog2(NUM_OAM)-1:0] oam_addr;
  sprite_conf_t               oam_data;
  logic [12:0]                pat_addr;
  logic [31:0]                pat_data;
  logic                       chain_clear;
  sprite_reg_t                out;
  logic                       out_valid;
  logic                       out_ack;
  logic                       busy;
  logic                       done;
`ifdef SPRITE_OVERFLOW_EN
  logic                       overflow;
`endif

  modport master (
`ifdef SPRITE_OVERFLOW_EN
    output overflow,
`endif
    output oam_addr, pat_addr, chain_clear, out, out_valid, busy, done,
    input  start, next_row, oam_data, pat_data, out_ack
  );

  modport slave (
`ifdef SPRITE_OVERFLOW_EN
    input  overflow,
`endif
    input  oam_addr, pat_addr, chain_clear, out, out_valid, busy, done,
    output start, next_row, oam_data, pat_data, out_ack
  );

endinterface
`default_nettype wire

// File: rtl/sprite_row_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_row_match: row hit test and row-within-sprite (tile row, py)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sprite_row_match (
  input  logic [7:0] row,
  input  logic [7:0] y,
  input  logic [1:0] h,
  input  logic       y_mirror,
  output logic       hit,
  output logic [1:0] ty,
  output logic [2:0] py
);

  logic [8:0] w_r;
  logic [8:0] w_h;
  logic [4:0] w_sr;

  assign w_r  = {1'b0, row} - {1'b0, y};
  assign w_h  = ({7'd0, h} + 9'd1) << 3;
  assign hit  = (row >= y) && (w_r < w_h);
  // Only meaningful on a hit, where r < 32 and fits the 5-bit result
  assign w_sr = y_mirror ? 5'(w_h - 9'd1 - w_r) : w_r[4:0];
  assign ty   = w_sr[4:3];
  assign py   = w_sr[2:0];

endmodule
`default_nettype wire

// File: rtl/sprite_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_loader: per-row OAM scan, pattern fetch and chain-head push.   |
// | Optional SPRITE_OVERFLOW_EN adds the overflow flag. Rev 1.0           |
// +----------------------------------------------------------------------+
module sprite_loader
  import sprite_loader_pkg::*;
#(
  parameter int NUM_OAM     = 64,
  parameter int MAX_SPRITES = 16
) (
  input  logic            clock,
  input  logic            reset,
  sprite_loader_if.master bus
);

  localparam int c_iw = $clog2(NUM_OAM);
  localparam int c_nw = $clog2(MAX_SPRITES + 1);
  localparam logic [c_iw-1:0] c_last   = c_iw'(NUM_OAM - 1);
  localparam logic [c_nw-1:0] c_max    = c_nw'(MAX_SPRITES);
  localparam logic [c_nw-1:0] c_max_m1 = c_nw'(MAX_SPRITES - 1);

  loader_state_t    r_state;
  logic [c_iw-1:0]  r_i;
  logic [c_nw-1:0]  r_n;
  logic [1:0]       r_k;
  logic [1:0]       r_ty;
  logic [2:0]       r_py;
  logic [7:0]       r_row;
  sprite_conf_t     r_conf;
  logic [31:0][3:0] r_pat;
  logic [12:0]      r_pat_addr;
  logic             r_chain_clear;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;
  logic             w_hit;
  logic [1:0]       w_ty;
  logic [2:0]       w_py;
  logic             w_last;
  logic             w_full;
  logic             w_stop;

  sprite_row_match u_match (
    .row      (r_row),
    .y        (bus.oam_data.y),
    .h        (bus.oam_data.h),
    .y_mirror (bus.oam_data.y_mirror),
    .hit      (w_hit),
    .ty       (w_ty),
    .py       (w_py)
  );

  assign w_last = (r_i == c_last);
  assign w_full = (r_n == c_max);
`ifdef SPRITE_OVERFLOW_EN
  // A full chain keeps scanning so later hits can raise overflow
  assign w_stop = w_last;
`else
  assign w_stop = w_last || (r_n == c_max_m1);
`endif

`ifdef SPRITE_OVERFLOW_EN
  logic r_overflow;
  always_ff @(posedge clock) begin
    if (reset)
      r_overflow <= 1'b0;
    else if (r_state == S_IDLE && bus.start)
      r_overflow <= 1'b0;
    else if (r_state == S_SCAN_CHECK && w_hit && w_full)
      r_overflow <= 1'b1;
  end
  assign bus.overflow = r_overflow;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_i           <= '0;
      r_n           <= '0;
      r_k           <= '0;
      r_ty          <= '0;
      r_py          <= '0;
      r_row         <= '0;
      r_conf        <= '0;
      r_pat         <= '0;
      r_pat_addr    <= '0;
      r_chain_clear <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_chain_clear <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_row         <= bus.next_row;
          r_i           <= '0;
          r_n           <= '0;
          r_chain_clear <= 1'b1;
          r_busy        <= 1'b1;
          r_state       <= S_CLEAR;
        end
        S_CLEAR:     r_state <= S_SCAN_ADDR;
        S_SCAN_ADDR: r_state <= S_SCAN_CHECK;
        S_SCAN_CHECK: begin
          if (w_hit && !w_full) begin
            r_conf     <= bus.oam_data;
            r_pat      <= '0;
            r_k        <= '0;
            r_ty       <= w_ty;
            r_py       <= w_py;
            r_pat_addr <= pat_word(bus.oam_data.tile, w_ty, 2'd0, w_py);
            r_state    <= S_FETCH_ADDR;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_i     <= r_i + c_iw'(1);
            r_state <= S_SCAN_ADDR;
          end
        end
        S_FETCH_ADDR: r_state <= S_FETCH_DATA;
        S_FETCH_DATA: begin
          for (int p = 0; p < 8; p++)
            r_pat[{r_k, 3'(p)}] <= bus.pat_data[4*p +: 4];
          if (r_k == r_conf.w) begin
            r_out_valid <= 1'b1;
            r_state     <= S_PUSH;
          end else begin
            r_k        <= r_k + 2'd1;
            r_pat_addr <= pat_word(r_conf.tile, r_ty, r_k + 2'd1, r_py);
            r_state    <= S_FETCH_ADDR;
          end
        end
        S_PUSH: if (bus.out_ack) begin
          r_out_valid <= 1'b0;
          r_n         <= r_n + c_nw'(1);
          if (w_stop) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_i     <= r_i + c_iw'(1);
            r_state <= S_SCAN_ADDR;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oam_addr    = r_i;
  assign bus.pat_addr    = r_pat_addr;
  assign bus.chain_clear = r_chain_clear;
  assign bus.out         = {r_conf, r_pat};
  assign bus.out_valid   = r_out_valid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule
`default_nettype wire
